// File: rtl/rename_regfile.sv
// Architectural register file with a per-register rename tag table.
// Commits from the reorder buffer write values and release tags. Issue
// renames a destination to a ROB tag. Each decoder lookup returns either
// the committed value or the ROB tag that will produce it. A same-cycle
// commit is forwarded into the lookup.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global ready; state holds while low
//   clr              misprediction flush: drop every rename tag
//   issue_*          rename request (rd, ROB tag)
//   commit_*         in-order register commit (rd, value, ROB tag)
//   rs1_*/rs2_*      combinational source lookups (busy, tag, value)
module rename_regfile #(
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 issue_en,
  input  logic [REG_W-1:0]     issue_rd,
  input  logic [ROB_POS_W:0]   issue_rob_pos,
  input  logic                 commit_en,
  input  logic [REG_W-1:0]     commit_rd,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W:0]   commit_rob_pos,
  input  logic [REG_W-1:0]     rs1_idx,
  input  logic [REG_W-1:0]     rs2_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_POS_W:0]   rs1_rob_pos,
  output logic [ROB_POS_W:0]   rs2_rob_pos,
  output logic [DATA_W-1:0]    rs1_val,
  output logic [DATA_W-1:0]    rs2_val
);

  localparam int unsigned TAG_W = ROB_POS_W + 1;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } lookup_t;

  logic [DATA_W-1:0] val_q  [REG_NUM];
  logic              busy_q [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];

  logic commit_wr;
  logic issue_wr;

  assign commit_wr = commit_en && (commit_rd != '0);
  assign issue_wr  = issue_en && !clr && (issue_rd != '0);

  // State update: rst > hold when !rdy > commit/clr/issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      // Commit value lands even under clr (e.g. JALR committing as it flushes).
      if (commit_wr) begin
        val_q[commit_rd] <= commit_val;
        // Release only if this commit is still the youngest rename of rd.
        if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_pos)) begin
          busy_q[commit_rd] <= 1'b0;
          tag_q[commit_rd]  <= '0;
        end
      end
      if (clr) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else if (issue_wr) begin
        // Later assignment wins over a same-cycle release of the same rd.
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  // One source lookup with commit forwarding.
  function automatic lookup_t do_lookup(input logic [REG_W-1:0] idx);
    lookup_t r;
    r = '0;
    if (idx == '0) begin
      r = '0;
    end else if (!busy_q[idx]) begin
      r.val = val_q[idx];
    end else if (commit_en && (commit_rd == idx) && (commit_rob_pos == tag_q[idx])) begin
      r.val = commit_val;
    end else begin
      r.busy = 1'b1;
      r.tag  = tag_q[idx];
    end
    return r;
  endfunction

  lookup_t rs1_lk;
  lookup_t rs2_lk;

  always_comb begin
    rs1_lk = do_lookup(rs1_idx);
    rs2_lk = do_lookup(rs2_idx);
  end

  assign rs1_busy    = rs1_lk.busy;
  assign rs1_rob_pos = rs1_lk.tag;
  assign rs1_val     = rs1_lk.val;
  assign rs2_busy    = rs2_lk.busy;
  assign rs2_rob_pos = rs2_lk.tag;
  assign rs2_val     = rs2_lk.val;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: rename, commit release, forwarding,
// younger-rename retention, issue-vs-commit collision, flush, x0 and rdy hold.
module tb_rename_regfile;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_POS_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              clr;
  logic              issue_en;
  logic [REG_W-1:0]  issue_rd;
  logic [ROB_POS_W:0] issue_rob_pos;
  logic              commit_en;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_val;
  logic [ROB_POS_W:0] commit_rob_pos;
  logic [REG_W-1:0]  rs1_idx;
  logic [REG_W-1:0]  rs2_idx;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [ROB_POS_W:0] rs1_rob_pos;
  logic [ROB_POS_W:0] rs2_rob_pos;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_regfile #(
    .REG_NUM(32), .REG_W(REG_W), .DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; issue_en = 1'b0; commit_en = 1'b0;
    issue_rd = '0; issue_rob_pos = '0;
    commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
  endtask

  task automatic issue(input logic [REG_W-1:0] rd, input logic [ROB_POS_W:0] tag);
    issue_en = 1'b1; issue_rd = rd; issue_rob_pos = tag;
  endtask

  task automatic commit(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] v,
                        input logic [ROB_POS_W:0] tag);
    commit_en = 1'b1; commit_rd = rd; commit_val = v; commit_rob_pos = tag;
  endtask

  // Compare the rs1 lookup (index already applied) after settle.
  task automatic expect_rs1(input string tag, input logic b, input logic [ROB_POS_W:0] p,
                            input logic [DATA_W-1:0] v);
    #1;
    check({tag, ".busy"}, 64'(rs1_busy), 64'(b));
    check({tag, ".pos"},  64'(rs1_rob_pos), 64'(p));
    check({tag, ".val"},  64'(rs1_val), 64'(v));
  endtask

  task automatic expect_rs2(input string tag, input logic b, input logic [ROB_POS_W:0] p,
                            input logic [DATA_W-1:0] v);
    #1;
    check({tag, ".busy"}, 64'(rs2_busy), 64'(b));
    check({tag, ".pos"},  64'(rs2_rob_pos), 64'(p));
    check({tag, ".val"},  64'(rs2_val), 64'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; idle();
    rs1_idx = '0; rs2_idx = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rs1_idx = 5'd5; rs2_idx = 5'd0;
    expect_rs1("rst_rs1", 1'b0, 5'h00, 32'h0);
    expect_rs2("rst_rs2", 1'b0, 5'h00, 32'h0);

    // Rename x3, forward its commit, then read from storage
    issue(5'd3, 5'h12); tick(); idle();
    rs1_idx = 5'd3;
    expect_rs1("x3_busy", 1'b1, 5'h12, 32'h0);
    commit(5'd3, 32'hDEADBEEF, 5'h12);
    expect_rs1("x3_fwd", 1'b0, 5'h00, 32'hDEADBEEF);
    tick(); idle();
    expect_rs1("x3_store", 1'b0, 5'h00, 32'hDEADBEEF);

    // Older commit must not release a younger rename
    issue(5'd7, 5'h11); tick();
    issue(5'd7, 5'h13); tick(); idle();
    rs1_idx = 5'd7;
    commit(5'd7, 32'd5, 5'h11);
    expect_rs1("x7_old_fwd", 1'b1, 5'h13, 32'h0);
    tick(); idle();
    expect_rs1("x7_still", 1'b1, 5'h13, 32'h0);
    commit(5'd7, 32'd9, 5'h13); tick(); idle();
    expect_rs1("x7_done", 1'b0, 5'h00, 32'd9);

    // Same-cycle issue and commit to x4: issue wins
    issue(5'd4, 5'h14); tick();
    issue(5'd4, 5'h15); commit(5'd4, 32'h40, 5'h14); tick(); idle();
    rs1_idx = 5'd4;
    expect_rs1("x4_issue_wins", 1'b1, 5'h15, 32'h0);
    commit(5'd4, 32'h41, 5'h15); tick(); idle();
    expect_rs1("x4_done", 1'b0, 5'h00, 32'h41);

    // Flush: give x2 a value, rename 1/2/3, then clr with commit x1 and issue x6
    commit(5'd2, 32'h22, 5'h10); tick(); idle();
    issue(5'd1, 5'h16); tick();
    issue(5'd2, 5'h17); tick();
    issue(5'd3, 5'h18); tick(); idle();
    rs1_idx = 5'd2;
    expect_rs1("x2_pre_clr", 1'b1, 5'h17, 32'h0);
    clr = 1'b1; commit(5'd1, 32'h100, 5'h16); issue(5'd6, 5'h19);
    tick(); idle();
    rs1_idx = 5'd1; rs2_idx = 5'd2;
    expect_rs1("clr_x1", 1'b0, 5'h00, 32'h100);
    expect_rs2("clr_x2", 1'b0, 5'h00, 32'h22);
    rs1_idx = 5'd3; rs2_idx = 5'd6;
    expect_rs1("clr_x3", 1'b0, 5'h00, 32'hDEADBEEF);
    expect_rs2("clr_x6", 1'b0, 5'h00, 32'h0);

    // x0 ignores commit and issue
    commit(5'd0, 32'hFF, 5'h1A); issue(5'd0, 5'h1A); tick(); idle();
    rs1_idx = 5'd0; rs2_idx = 5'd0;
    expect_rs1("x0_rs1", 1'b0, 5'h00, 32'h0);
    expect_rs2("x0_rs2", 1'b0, 5'h00, 32'h0);

    // rdy low holds state; same requests take effect once rdy returns
    rdy = 1'b0;
    issue(5'd8, 5'h1B); commit(5'd9, 32'h99, 5'h1C); tick();
    rs1_idx = 5'd8; rs2_idx = 5'd9;
    expect_rs1("hold_x8", 1'b0, 5'h00, 32'h0);
    expect_rs2("hold_x9", 1'b0, 5'h00, 32'h0);
    rdy = 1'b1; tick(); idle();
    expect_rs1("rdy_x8", 1'b1, 5'h1B, 32'h0);
    expect_rs2("rdy_x9", 1'b0, 5'h00, 32'h99);

    // Reset clears storage and tags
    rst = 1'b1; tick(); rst = 1'b0;
    expect_rs1("rst2_x8", 1'b0, 5'h00, 32'h0);
    expect_rs2("rst2_x9", 1'b0, 5'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file plus rename-tag table.
- Receives in-order commits from the reorder buffer (rd, value, ROB position) and rename requests from issue (rd, ROB position).
- Answers the decoder's rs1/rs2 lookups with either a committed value or the ROB position that will produce it.
- Forwards a same-cycle commit to the lookup.
- Drops all rename tags on a misprediction flush (clr) and keeps committed values.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 hardwired to zero.
- REG_W, 5, register index width.
- DATA_W, 32, register data width.
- ROB_POS_W, 4, ROB index width. Tags are ROB_POS_W+1 bits, MSB = 1 for any valid tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when low, state holds
- clr  in  1  misprediction flush from ROB
- issue_en  in  1  rename rd to issue_rob_pos this cycle
- issue_rd  in  REG_W  destination register of issuing instruction
- issue_rob_pos  in  ROB_POS_W+1  ROB tag of issuing instruction
- commit_en  in  1  ROB register commit valid
- commit_rd  in  REG_W  committed destination
- commit_val  in  DATA_W  committed value
- commit_rob_pos  in  ROB_POS_W+1  ROB tag of committing entry
- rs1_idx, rs2_idx  in  REG_W  decoder source indices
- rs1_busy, rs2_busy  out  1  source still awaits an uncommitted ROB entry
- rs1_rob_pos, rs2_rob_pos  out  ROB_POS_W+1  producing ROB tag; 0 when not busy
- rs1_val, rs2_val  out  DATA_W  register value; don't-care (driven 0) when busy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset all values = 0, busy = 0, tags = 0. Lookup outputs are combinational and therefore read 0 / not busy / tag 0 the cycle after reset. Reset overrides clr, rdy and all other inputs.
- Priority at posedge, in order: rst > !rdy (hold everything) > update.
- Commit write: if commit_en and commit_rd != 0, then val[commit_rd] <= commit_val, regardless of clr. A JALR commit and clr arrive in the same cycle, so the write must land.
- Commit tag release: if commit_en, commit_rd != 0, busy[commit_rd] and tag[commit_rd] == commit_rob_pos, then busy <= 0 and tag <= 0. If the tag differs, a younger rename exists; busy and tag are unchanged.
- Issue rename: if issue_en, !clr and issue_rd != 0, then busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
- Issue and commit to the same rd in the same cycle: issue wins. Busy stays 1 with the new tag; the value is still written.
- clr: busy and tag of every register <= 0. issue_en is ignored that cycle. Values are retained except for the commit write above.
- x0: never written, never busy. Lookups of index 0 return val 0, busy 0, tag 0.
- Lookup (combinational, per source, with forwarding), evaluated in order:
  - Index 0: val 0, busy 0, tag 0.
  - Else if !busy[idx]: val = val[idx], busy 0, tag 0.
  - Else if commit_en, commit_rd == idx and commit_rob_pos == tag[idx]: val = commit_val, busy 0, tag 0 (forwarding).
  - Else: val 0, busy 1, tag = tag[idx].
- Lookup is not affected by a same-cycle issue. The decoder must not look up the rd it is currently renaming.
- rdy low: no state changes; lookups still reflect current state and current commit inputs.
- Tag compare covers all ROB_POS_W+1 bits. ROB wrap-around is handled because each rd holds only its youngest tag.

Test Plan:
- Reset, then look up rs1 = 5, rs2 = 0 → val 0, busy 0, tag 0 on both.
- Issue rd = 3 with tag 0x12; next cycle look up rs1 = 3 → busy 1, rob_pos 0x12. Commit rd = 3, val 0xDEADBEEF, tag 0x12, with rs1 = 3 the same cycle → forwarded val 0xDEADBEEF, busy 0. Next cycle → val 0xDEADBEEF, busy 0 from storage.
- Issue rd = 7 tag 0x11, then rd = 7 tag 0x13. Commit rd = 7 tag 0x11 val 5 → rs1 = 7 shows busy 1, tag 0x13. Commit tag 0x13 val 9 → busy 0, val 9.
- Same-cycle issue rd = 4 tag 0x15 and commit rd = 4 tag 0x14 val 0x40 (old tag 0x14) → next cycle busy 1, tag 0x15. After commit of 0x15 with val 0x41 → val 0x41.
- Rename rd = 1, 2, 3. Pulse clr together with commit rd = 1 val 0x100 tag = tag[1], plus issue rd = 6 → next cycle: regs 1, 2, 3, 6 all not busy; x1 = 0x100; x2 and x3 keep their old values.
- Writes to x0 via commit (val 0xFF) and issue → x0 reads 0, not busy. With rdy = 0, issue and commit are both ignored, then take effect once rdy returns to 1.
